// File: rtl/player_pkg.sv
// Shared types and constants for the player controller: direction codes, fire FSM states,
// key bit positions and a saturating single-axis step helper.
package player_pkg;

   localparam int COORD_W   = 10;

   localparam int KEY_UP    = 3;
   localparam int KEY_DOWN  = 2;
   localparam int KEY_LEFT  = 1;
   localparam int KEY_RIGHT = 0;

   typedef enum logic [1:0] {
      DIR_UP    = 2'd0,
      DIR_DOWN  = 2'd1,
      DIR_LEFT  = 2'd2,
      DIR_RIGHT = 2'd3
   } dir_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_COOL = 2'd2
   } fire_state_e;

   // One axis, one tick: the extra top bit keeps cur+step from wrapping before the clamp.
   function automatic logic [COORD_W-1:0] step_axis(input logic [COORD_W-1:0] cur,
                                                    input logic dec,
                                                    input logic inc,
                                                    input int   step,
                                                    input int   max_v);
      logic [COORD_W:0] ext;
      logic [COORD_W:0] stp;
      logic [COORD_W:0] lim;
      logic [COORD_W:0] res;
      ext = {1'b0, cur};
      stp = (COORD_W+1)'(step);
      lim = (COORD_W+1)'(max_v);
      res = ext;
      if (dec && !inc)
         res = (ext < stp) ? '0 : ext - stp;
      else if (inc && !dec)
         res = (ext + stp > lim) ? lim : ext + stp;
      return res[COORD_W-1:0];
   endfunction

endpackage

// File: rtl/move_tick_gen.sv
// Free-running divider producing a one-cycle move tick every MOVE_DIV clocks.
module move_tick_gen
   import player_pkg::*;
#(
   parameter int MOVE_DIV = 250000
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int               CNT_W    = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MOVE_DIV - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      tick  = (cnt_q == CNT_LAST);
      cnt_d = tick ? '0 : cnt_q + 1'b1;
   end

   // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

endmodule

// File: rtl/player_ctrl.sv
// Player position/facing tracker with a rate-limited valid/ready fire request.
// Define AUTO_FIRE_EN to re-fire while shoot is held; default is one shot per press.
module player_ctrl
   import player_pkg::*;
#(
   parameter int X_MAX    = 639,
   parameter int Y_MAX    = 479,
   parameter int X_INIT   = 320,
   parameter int Y_INIT   = 240,
   parameter int STEP     = 4,
   parameter int MOVE_DIV = 250000,
   parameter int COOLDOWN = 25
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [3:0]         nums,
   input  logic               shoot,
   output logic [COORD_W-1:0] pos_x,
   output logic [COORD_W-1:0] pos_y,
   output logic [1:0]         facing,
   output logic               fire_valid,
   input  logic               fire_ready,
   output logic [COORD_W-1:0] fire_x,
   output logic [COORD_W-1:0] fire_y,
   output logic [1:0]         fire_dir
);

   localparam int CD_W = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

   logic               tick;
   logic               fire_cond;
   logic [COORD_W-1:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
   logic [COORD_W-1:0] fire_x_q, fire_x_d, fire_y_q, fire_y_d;
   dir_e               facing_q, facing_d, fire_dir_q, fire_dir_d;
   fire_state_e        state_q, state_d;
   logic               fire_valid_q, fire_valid_d;
   logic [CD_W-1:0]    cd_q, cd_d;

   move_tick_gen #(.MOVE_DIV(MOVE_DIV)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

`ifdef AUTO_FIRE_EN
   assign fire_cond = shoot;
`else
   logic armed_q, armed_d;

   // Re-arms only after the key is seen released, so a held key fires once.
   always_comb begin
      armed_d = armed_q;
      if (!shoot)                          armed_d = 1'b1;
      else if (state_q == ST_IDLE && armed_q) armed_d = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) armed_q <= 1'b0;
      else     armed_q <= armed_d;
   end

   assign fire_cond = shoot & armed_q;
`endif

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      pos_x_d  = pos_x_q;
      pos_y_d  = pos_y_q;
      facing_d = facing_q;
      if (tick) begin
         pos_y_d = step_axis(pos_y_q, nums[KEY_UP], nums[KEY_DOWN], STEP, Y_MAX);
         pos_x_d = step_axis(pos_x_q, nums[KEY_LEFT], nums[KEY_RIGHT], STEP, X_MAX);
      end
      if      (nums[KEY_UP])    facing_d = DIR_UP;
      else if (nums[KEY_DOWN])  facing_d = DIR_DOWN;
      else if (nums[KEY_LEFT])  facing_d = DIR_LEFT;
      else if (nums[KEY_RIGHT]) facing_d = DIR_RIGHT;
   end

   always_comb begin
      state_d    = state_q;
      cd_d       = cd_q;
      fire_x_d   = fire_x_q;
      fire_y_d   = fire_y_q;
      fire_dir_d = fire_dir_q;
      case (state_q)
         ST_IDLE: if (fire_cond) begin
            fire_x_d   = pos_x_q;
            fire_y_d   = pos_y_q;
            fire_dir_d = facing_q;
            state_d    = ST_REQ;
         end
         ST_REQ: if (fire_valid_q && fire_ready) begin
            state_d = ST_COOL;
            cd_d    = CD_W'(COOLDOWN);
         end
         ST_COOL: begin
            if (cd_q == '0) state_d = ST_IDLE;
            else if (tick)  cd_d    = cd_q - 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
      fire_valid_d = (state_d == ST_REQ);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pos_x_q      <= COORD_W'(X_INIT);
         pos_y_q      <= COORD_W'(Y_INIT);
         facing_q     <= DIR_UP;
         state_q      <= ST_IDLE;
         fire_valid_q <= 1'b0;
         cd_q         <= '0;
         fire_x_q     <= '0;
         fire_y_q     <= '0;
         fire_dir_q   <= DIR_UP;
      end else begin
         pos_x_q      <= pos_x_d;
         pos_y_q      <= pos_y_d;
         facing_q     <= facing_d;
         state_q      <= state_d;
         fire_valid_q <= fire_valid_d;
         cd_q         <= cd_d;
         fire_x_q     <= fire_x_d;
         fire_y_q     <= fire_y_d;
         fire_dir_q   <= fire_dir_d;
      end
   end

   assign pos_x      = pos_x_q;
   assign pos_y      = pos_y_q;
   assign facing     = facing_q;
   assign fire_valid = fire_valid_q;
   assign fire_x     = fire_x_q;
   assign fire_y     = fire_y_q;
   assign fire_dir   = fire_dir_q;

endmodule
